qed_commit_checker: RTL and testbench
=====================================

# qed_commit_checker

Writeback-side consistency checker for QED mode: the counterpart at the commit end of the instruction stream that the QED front end duplicates. It records every original-register writeback (x1–x15) in an in-order FIFO. It compares each later duplicate-register writeback (x17–x31) against the oldest recorded original. It reports per-comparison results, sticky mismatch/overflow/underflow errors, and a "consistent" status for the formal property checker.

## Interface
- DEPTH, 16, FIFO entries (power of two, ≥2)
- XLEN, 32, writeback data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ena  in  1  QED mode enable; low flushes the FIFO
- wb_vld  in  1  a register writeback commits this cycle
- wb_rd  in  5  destination register of the writeback
- wb_data  in  XLEN  value written
- qed_check_vld  out  1  one-cycle pulse: a comparison completed
- qed_check_ok  out  1  result of that comparison; valid only with qed_check_vld
- qed_mismatch  out  1  sticky: some comparison failed
- qed_err_rd  out  5  original rd of the first failing comparison
- qed_overflow  out  1  sticky: original write dropped because FIFO full
- qed_underflow  out  1  sticky: duplicate write arrived with FIFO empty
- qed_pending  out  $clog2(DEPTH)+1  current FIFO occupancy
- qed_consistent  out  1  ena & pending==0 & no sticky error

## Operation
- Classification, when ena=1 and wb_vld=1:
  - wb_rd[4]=0 and wb_rd≠0: original write. Push {wb_rd[3:0], wb_data}.
  - wb_rd[4]=1 and wb_rd≠16: duplicate write. Pop the head and compare.
  - wb_rd=0 or wb_rd=16: ignored.
- One writeback per cycle, so a push and a pop never occur in the same cycle.
- Compare rule: ok = (head.rd == wb_rd[3:0]) & (head.data == wb_data). Mapping is duplicate = original + 16.
- Failure handling:
  - ok=0 sets qed_mismatch.
  - On the first failure only, qed_err_rd loads {1'b0, head.rd}; later failures leave it unchanged.
- Full FIFO plus an original write: the entry is dropped, qed_overflow is set, and occupancy is unchanged.
- Empty FIFO plus a duplicate write:
  - qed_underflow is set.
  - qed_check_vld pulses with qed_check_ok=0.
  - qed_mismatch is set, and qed_err_rd loads wb_rd if this is the first failure.
- ena=0:
  - At the next edge, the read/write pointers and occupancy clear.
  - Sticky flags and qed_err_rd hold their values.
  - No pushes, pops or pulses occur.
- Sticky flags clear only on reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter, 0..DEPTH.

## Timing
- Reset values:
  - qed_check_vld=0, qed_check_ok=0, qed_mismatch=0, qed_err_rd=0
  - qed_overflow=0, qed_underflow=0, qed_pending=0
  - qed_consistent=0 while ena=0, and follows ena after reset.
  - FIFO pointers=0.
- Reset asserted mid-stream: all state clears immediately; no pulse is emitted after reset releases.
- Latency: a duplicate write at edge N produces qed_check_vld/qed_check_ok registered, visible during cycle N+1.
- qed_mismatch, qed_err_rd, qed_overflow and qed_underflow update at that same edge.
- qed_pending is registered and reflects a push or pop one cycle after the write.
- qed_consistent is combinational from registered state.
- Back-to-back duplicate writes give back-to-back qed_check_vld pulses with no bubble.
- A push into an empty FIFO followed immediately by a pop of that entry is legal. The head is read from registered storage, so no bypass is needed.

## Test plan
- Matched pair:
  - Stimulus: writes x5=0xDEAD_BEEF, then x21=0xDEAD_BEEF.
  - Response: check_vld=1 and check_ok=1 in the cycle after the x21 write; pending goes 0→1→0; consistent=1 at end; no sticky flags.
- Data mismatch:
  - Stimulus: writes x3=0x10, x4=0x20, then x19=0x10, x20=0x21.
  - Response: second comparison gives ok=0, mismatch=1, err_rd=4; a later mismatch on x7/x23 leaves err_rd=4.
- Wrong order:
  - Stimulus: writes x1=1, x2=2, then x18=2.
  - Response: ok=0, err_rd=1, pending=1 after the pop.
- Overflow with DEPTH=16:
  - Stimulus: 17 original writes.
  - Response: pending saturates at 16 and overflow=1. Then 16 matching duplicate writes give 16 ok pulses, and the first 16 entries are intact.
- Underflow and ignore rules:
  - Stimulus: writes x0=7, x16=7, then x17=9 with the FIFO empty.
  - Response: the x0 and x16 writes cause no push or pulse. The x17 write gives underflow=1, ok=0, mismatch=1, err_rd=17.
- Flush and reset:
  - Stimulus: push 3 originals, drop ena for 1 cycle, then re-raise ena.
  - Response: pending=0 and sticky flags unchanged.
  - Then: assert rst asynchronously mid-stream.
  - Response: all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/qed_wb_if.sv
// Writeback commit bus observed by the QED commit checker.
interface qed_wb_if #(
  parameter int XLEN = 32
);
  logic            wb_vld;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (output wb_vld, output wb_rd, output wb_data);
  modport slave  (input  wb_vld, input  wb_rd, input  wb_data);
endinterface

// File: rtl/qed_commit_checker.sv
// QED commit-side checker: queues original writebacks (x1-x15) in order and
// compares each duplicate writeback (x17-x31) against the oldest queued original.
module qed_commit_checker #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  qed_wb_if.slave                wb,
  output logic                   qed_check_vld,
  output logic                   qed_check_ok,
  output logic                   qed_mismatch,
  output logic [4:0]             qed_err_rd,
  output logic                   qed_overflow,
  output logic                   qed_underflow,
  output logic [$clog2(DEPTH):0] qed_pending,
  output logic                   qed_consistent
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  logic [3:0]      rd_mem_r   [DEPTH];
  logic [XLEN-1:0] data_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;

  logic       orig_s;
  logic       dup_s;
  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       pop_s;
  logic       match_s;
  logic       fail_s;
  logic [4:0] fail_rd_s;

  // Classify the writeback and evaluate the head comparison.
  always_comb begin
    orig_s    = 1'b0;
    dup_s     = 1'b0;
    fail_rd_s = 5'd0;
    if (ena && wb.wb_vld && (wb.wb_rd[3:0] != 4'd0)) begin
      orig_s = ~wb.wb_rd[4];
      dup_s  = wb.wb_rd[4];
    end else begin
      orig_s = 1'b0;
      dup_s  = 1'b0;
    end
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == CNT_ZERO);
    push_s  = orig_s & ~full_s;
    pop_s   = dup_s & ~empty_s;
    match_s = pop_s & (rd_mem_r[rd_ptr_r] == wb.wb_rd[3:0])
                    & (data_mem_r[rd_ptr_r] == wb.wb_data);
    fail_s  = dup_s & ~match_s;
    // An empty-FIFO duplicate has no head, so blame the duplicate register itself.
    if (pop_s) begin
      fail_rd_s = {1'b0, rd_mem_r[rd_ptr_r]};
    end else begin
      fail_rd_s = wb.wb_rd;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= 4'd0;
        data_mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      rd_mem_r[wr_ptr_r]   <= wb.wb_rd[3:0];
      data_mem_r[wr_ptr_r] <= wb.wb_data;
    end
  end

  // Pointers and occupancy; dropping ena flushes the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (!ena) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (push_s) begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
      count_r  <= count_r + CNT_ONE;
    end else if (pop_s) begin
      rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r  <= count_r - CNT_ONE;
    end
  end

  // Comparison pulse and sticky error reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qed_check_vld <= 1'b0;
      qed_check_ok  <= 1'b0;
      qed_mismatch  <= 1'b0;
      qed_err_rd    <= 5'd0;
      qed_overflow  <= 1'b0;
      qed_underflow <= 1'b0;
    end else begin
      qed_check_vld <= dup_s;
      qed_check_ok  <= match_s;
      if (fail_s) begin
        qed_mismatch <= 1'b1;
      end
      if (fail_s && !qed_mismatch) begin
        qed_err_rd <= fail_rd_s;
      end
      if (orig_s && full_s) begin
        qed_overflow <= 1'b1;
      end
      if (dup_s && empty_s) begin
        qed_underflow <= 1'b1;
      end
    end
  end

  assign qed_pending    = count_r;
  assign qed_consistent = ena & (count_r == CNT_ZERO) & ~qed_mismatch
                              & ~qed_overflow & ~qed_underflow;
endmodule

// File: tb/tb_qed_commit_checker.sv
// Randomized and directed bench for qed_commit_checker against a queue-based model.
module tb_qed_commit_checker;
  localparam int DEPTH = 16;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [3:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk;
  logic rst;
  logic ena;
  logic qed_check_vld, qed_check_ok, qed_mismatch, qed_overflow, qed_underflow;
  logic qed_consistent;
  logic [4:0] qed_err_rd;
  logic [$clog2(DEPTH):0] qed_pending;

  qed_wb_if #(.XLEN(XLEN)) wb_if ();

  qed_commit_checker #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .wb             (wb_if.slave),
    .qed_check_vld  (qed_check_vld),
    .qed_check_ok   (qed_check_ok),
    .qed_mismatch   (qed_mismatch),
    .qed_err_rd     (qed_err_rd),
    .qed_overflow   (qed_overflow),
    .qed_underflow  (qed_underflow),
    .qed_pending    (qed_pending),
    .qed_consistent (qed_consistent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  ent_t       q[$];
  bit         m_vld, m_ok, m_mis, m_ovf, m_unf;
  logic [4:0] m_err;

  logic [3:0]      orr [17];
  logic [XLEN-1:0] od  [17];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_vld = 0; m_ok = 0; m_mis = 0; m_ovf = 0; m_unf = 0; m_err = 5'd0;
  endtask

  task automatic model_step(input bit e, input bit v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    ent_t       h;
    logic [4:0] frd;
    m_vld = 0;
    m_ok  = 0;
    if (!e) begin
      q.delete();
    end else if (v && rd[3:0] != 4'd0) begin
      if (!rd[4]) begin
        if (q.size() < DEPTH) q.push_back('{rd: rd[3:0], data: d});
        else m_ovf = 1;
      end else begin
        m_vld = 1;
        if (q.size() == 0) begin
          m_unf = 1;
          frd   = rd;
        end else begin
          h    = q.pop_front();
          m_ok = (h.rd == rd[3:0]) && (h.data == d);
          frd  = {1'b0, h.rd};
        end
        if (!m_ok) begin
          if (!m_mis) m_err = frd;
          m_mis = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("check_vld", qed_check_vld, m_vld);
    if (m_vld) check("check_ok", qed_check_ok, m_ok);
    check("mismatch", qed_mismatch, m_mis);
    check("err_rd", qed_err_rd, m_err);
    check("overflow", qed_overflow, m_ovf);
    check("underflow", qed_underflow, m_unf);
    check("pending", qed_pending, q.size());
    check("consistent", qed_consistent,
          ena && q.size() == 0 && !m_mis && !m_ovf && !m_unf);
  endtask

  // Drive at negedge, apply one clock edge, compare at the following negedge.
  task automatic step(input bit e, input bit v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    ena = e;
    wb_if.wb_vld  = v;
    wb_if.wb_rd   = rd;
    wb_if.wb_data = d;
    @(posedge clk);
    model_step(e, v, rd, d);
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_vld", qed_check_vld, 1'b0);
    check("rst_ok", qed_check_ok, 1'b0);
    check("rst_mismatch", qed_mismatch, 1'b0);
    check("rst_err_rd", qed_err_rd, 5'd0);
    check("rst_overflow", qed_overflow, 1'b0);
    check("rst_underflow", qed_underflow, 1'b0);
    check("rst_pending", qed_pending, 0);
    check("rst_consistent", qed_consistent, ena);
    wb_if.wb_vld = 1'b0;
    ena = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    ena = 1'b0;
    wb_if.wb_vld  = 1'b0;
    wb_if.wb_rd   = 5'd0;
    wb_if.wb_data = 32'd0;
    model_clear();
    @(negedge clk);
    check("init_consistent_ena0", qed_consistent, 1'b0);
    check("init_pending", qed_pending, 0);
    ena = 1'b1;
    #1;
    check("init_consistent_ena1", qed_consistent, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 5'd0, 32'd0);

    // Matched pair
    step(1, 1, 5'd5, 32'hDEAD_BEEF);
    check("pair_pending1", qed_pending, 1);
    step(1, 1, 5'd21, 32'hDEAD_BEEF);
    check("pair_vld", qed_check_vld, 1'b1);
    check("pair_ok", qed_check_ok, 1'b1);
    check("pair_pending0", qed_pending, 0);
    check("pair_consistent", qed_consistent, 1'b1);

    // Data mismatch, then a later failure keeps the first err_rd
    step(1, 1, 5'd3, 32'h10);
    step(1, 1, 5'd4, 32'h20);
    step(1, 1, 5'd19, 32'h10);
    step(1, 1, 5'd20, 32'h21);
    check("dm_ok", qed_check_ok, 1'b0);
    check("dm_err_rd", qed_err_rd, 5'd4);
    step(1, 1, 5'd7, 32'h5);
    step(1, 1, 5'd23, 32'h6);
    check("dm_err_rd_hold", qed_err_rd, 5'd4);
    check("dm_vld_before_rst", qed_check_vld, 1'b1);
    async_reset();

    // Wrong order
    step(1, 1, 5'd1, 32'd1);
    step(1, 1, 5'd2, 32'd2);
    step(1, 1, 5'd18, 32'd2);
    check("wo_ok", qed_check_ok, 1'b0);
    check("wo_err_rd", qed_err_rd, 5'd1);
    check("wo_pending", qed_pending, 1);
    async_reset();

    // Overflow: 17 originals, then 16 matching duplicates
    for (int i = 0; i < 17; i++) begin
      orr[i] = 4'(i % 15 + 1);
      od[i]  = $urandom;
      step(1, 1, {1'b0, orr[i]}, od[i]);
    end
    check("ovf_pending", qed_pending, 16);
    check("ovf_flag", qed_overflow, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, {1'b1, orr[i]}, od[i]);
      check("ovf_dup_ok", qed_check_ok, 1'b1);
    end
    check("ovf_no_mismatch", qed_mismatch, 1'b0);
    check("ovf_drained", qed_pending, 0);
    async_reset();

    // Ignore rules and underflow
    step(1, 1, 5'd0, 32'd7);
    step(1, 1, 5'd16, 32'd7);
    check("ign_vld", qed_check_vld, 1'b0);
    check("ign_pending", qed_pending, 0);
    step(1, 1, 5'd17, 32'd9);
    check("unf_flag", qed_underflow, 1'b1);
    check("unf_ok", qed_check_ok, 1'b0);
    check("unf_err_rd", qed_err_rd, 5'd17);

    // Flush keeps sticky flags
    step(1, 1, 5'd1, 32'd11);
    step(1, 1, 5'd2, 32'd12);
    step(1, 1, 5'd3, 32'd13);
    check("fl_pending3", qed_pending, 3);
    step(0, 1, 5'd4, 32'd14);
    step(1, 0, 5'd0, 32'd0);
    check("fl_pending0", qed_pending, 0);
    check("fl_underflow_kept", qed_underflow, 1'b1);
    check("fl_err_rd_kept", qed_err_rd, 5'd17);
    async_reset();

    // Randomized traffic
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 300; n++) begin
        bit              e, v;
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
        int              k;
        e = ($urandom_range(0, 99) >= 3);
        v = ($urandom_range(0, 99) < 80);
        k = $urandom_range(0, 99);
        if (k < 45) begin
          rd = {1'b0, 4'($urandom_range(1, 15))};
          d  = $urandom;
        end else if (k < 88 && q.size() > 0) begin
          rd = {1'b1, q[0].rd};
          d  = q[0].data;
        end else begin
          rd = 5'($urandom_range(0, 31));
          d  = 32'($urandom_range(0, 3));
        end
        step(e, v, rd, d);
      end
      async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
